ddr3_dq_dir_ctrl: RTL and testbench
===================================

# ddr3_dq_dir_ctrl

Sequencer and arbiter for the bidirectional DQ/DQS pad buffers of one DDR3 byte-lane group. Grants the shared DQ bus to one read or write burst at a time and drives the active-high tristate controls (T=1 read/high-Z, T=0 drive) of the DQ and DQS IOBUFs. Inserts DQS preamble, postamble and bus-turnaround gaps, and generates the write-data and read-capture enable windows. Sits between the command scheduler and the PHY pad buffers.

## Interface
- LANES, 8: number of DQ/DQS lane groups sharing one direction decision
- BURST_BEATS, 4: controller-clock cycles of data per burst, ≥1
- PREAMBLE_CYCLES, 1: DQS-driven, DQ-tristated cycles before write data, ≥1
- POSTAMBLE_CYCLES, 1: DQS-driven, DQ-tristated cycles after write data, ≥1
- TURNAROUND_CYCLES, 2: all-tristated idle cycles after any burst, ≥1

- i_controller_clk  in  1  sole clock; everything is on its rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_wr_req  in  1  write burst request, level, held until granted
- i_rd_req  in  1  read burst request, level, held until granted
- o_wr_gnt  out  1  one-cycle write grant pulse
- o_rd_gnt  out  1  one-cycle read grant pulse
- o_dq_t  out  LANES  DQ IOBUF T per lane, all bits identical
- o_dqs_t  out  LANES  DQS IOBUF T per lane, all bits identical
- o_wr_data_en  out  1  high during write data cycles
- o_rd_capture_en  out  1  high during read data cycles
- o_busy  out  1  high whenever state ≠ IDLE
- o_state  out  3  current state encoding: IDLE=0, WR_PRE=1, WR_DATA=2, WR_POST=3, RD_DATA=4, TURN=5

## Operation
- All outputs are registered. Reset values: o_dq_t and o_dqs_t all-ones; o_wr_gnt, o_rd_gnt, o_wr_data_en, o_rd_capture_en, and o_busy 0; o_state IDLE. Internal last_grant resets to READ, so a write wins the first tie.
- Reset is honoured at any point, including mid-burst. All outputs return to their reset values asynchronously, and the counter clears.
- One down-counter, width clog2(max parameter)+1, loaded on each state entry with the state length minus 1. The state advances when the counter reaches 0.
- IDLE: o_dq_t and o_dqs_t are 1.
  - Only one request: grant it.
  - Both requests: grant the opposite of last_grant (round-robin).
  - Write grant → WR_PRE. Read grant → RD_DATA.
  - The grant pulse and the state change occur on the same edge. last_grant is updated at that edge.
- WR_PRE (PREAMBLE_CYCLES): o_dqs_t=0, o_dq_t=1.
- WR_DATA (BURST_BEATS): o_dqs_t=0, o_dq_t=0, o_wr_data_en=1.
  - On the final beat, if i_wr_req=1 and i_rd_req=0: pulse o_wr_gnt, reload the counter, and stay in WR_DATA. This is a seamless write with no post/preamble.
  - Otherwise go to WR_POST.
- WR_POST (POSTAMBLE_CYCLES): o_dqs_t=0, o_dq_t=1 → TURN.
- RD_DATA (BURST_BEATS): all T=1, o_rd_capture_en=1 → TURN. Reads are never chained seamlessly.
- TURN (TURNAROUND_CYCLES): all T=1 → IDLE. Requests are ignored here.
- Requests are sampled only in IDLE and on the final WR_DATA beat. A requester drops its request in the cycle after seeing its grant.

## Timing
- Request high before edge k in IDLE → at edge k: grant=1 for one cycle and the state leaves IDLE.
- Write at edge k:
  - o_dqs_t falls at edge k.
  - o_wr_data_en is high for edges k+P … k+P+B−1.
  - o_dq_t is 0 for the same window.
  - o_dqs_t rises at edge k+P+B+Q.
  - IDLE is re-entered at k+P+B+Q+T.
  - (P, B, Q, T = preamble, burst, postamble, turnaround.)
- Read at edge k: o_rd_capture_en is high for edges k … k+B−1, and IDLE is re-entered at k+B+T.
- Minimum gaps between bursts:
  - Write→read: Q+T+1 cycles of no data.
  - Read→write: T+1+P cycles.
  - Write→write seamless: 0.

## Test plan
- Reset: assert i_rst_n=0 mid-WR_DATA → o_dq_t=o_dqs_t=8'hFF and o_wr_data_en=0 immediately, without waiting for a clock edge. After release, o_state=0.
- Single write, defaults: i_wr_req at edge 10 → o_wr_gnt pulse at edge 10, o_dqs_t=0 for edges 10–15, o_wr_data_en for edges 11–14, IDLE at edge 18.
- Single read, defaults: i_rd_req at edge 10 → o_rd_gnt at edge 10, o_rd_capture_en for edges 10–13, IDLE at edge 16, o_dq_t held at 8'hFF throughout.
- Tie from reset: both requests held → write granted first, then read after the turnaround, then write again (alternation).
- Seamless writes: i_wr_req re-asserted, i_rd_req=0 → 8 contiguous o_wr_data_en cycles, a second o_wr_gnt on the final beat of the first burst, and no o_dqs_t release between the bursts.
- Back-to-back read→write → the first write data cycle comes ≥ T+1+P=4 cycles after the last read capture cycle. o_dq_t and o_dqs_t are never 0 while o_rd_capture_en=1.

Source files
------------

// File: rtl/ddr3_dq_dir_ctrl.sv
// DQ/DQS direction sequencer for one DDR3 byte-lane group.
// Arbitrates read/write bursts onto the shared DQ bus and drives the IOBUF
// tristate controls (T=1 high-Z, T=0 drive), inserting preamble, postamble
// and turnaround gaps. Every output is registered off the next-state value,
// so each output reflects the state entered at the same edge.
module ddr3_dq_dir_ctrl #(
  parameter int LANES             = 8,
  parameter int BURST_BEATS       = 4,
  parameter int PREAMBLE_CYCLES   = 1,
  parameter int POSTAMBLE_CYCLES  = 1,
  parameter int TURNAROUND_CYCLES = 2
) (
  input  logic             i_controller_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_req,
  input  logic             i_rd_req,
  output logic             o_wr_gnt,
  output logic             o_rd_gnt,
  output logic [LANES-1:0] o_dq_t,
  output logic [LANES-1:0] o_dqs_t,
  output logic             o_wr_data_en,
  output logic             o_rd_capture_en,
  output logic             o_busy,
  output logic [2:0]       o_state
);

  localparam int MAX_A   = (BURST_BEATS > PREAMBLE_CYCLES) ? BURST_BEATS : PREAMBLE_CYCLES;
  localparam int MAX_B   = (POSTAMBLE_CYCLES > TURNAROUND_CYCLES) ? POSTAMBLE_CYCLES : TURNAROUND_CYCLES;
  localparam int MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(MAX_LEN) + 1;

  // Counter load values: each state runs for (length) cycles, counting down to 0.
  localparam logic [CW-1:0] PRE_LD  = CW'(PREAMBLE_CYCLES - 1);
  localparam logic [CW-1:0] BST_LD  = CW'(BURST_BEATS - 1);
  localparam logic [CW-1:0] POST_LD = CW'(POSTAMBLE_CYCLES - 1);
  localparam logic [CW-1:0] TURN_LD = CW'(TURNAROUND_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_PRE  = 3'd1,
    WR_DATA = 3'd2,
    WR_POST = 3'd3,
    RD_DATA = 3'd4,
    TURN    = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last_wr, last_wr_nxt;   // 1 = last grant was a write
  logic          wr_gnt_nxt, rd_gnt_nxt;
  logic          cnt_done;

  assign cnt_done = (cnt == '0);

  // State, counter and round-robin history registers.
  always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      last_wr <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      last_wr <= last_wr_nxt;
    end
  end

  // Next-state, counter reload and grant decisions.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt_done ? cnt : cnt - CW'(1);
    last_wr_nxt = last_wr;
    wr_gnt_nxt  = 1'b0;
    rd_gnt_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        // Write wins if alone, or on a tie when the previous grant was a read.
        if (i_wr_req && (!i_rd_req || !last_wr)) begin
          wr_gnt_nxt  = 1'b1;
          last_wr_nxt = 1'b1;
          state_nxt   = WR_PRE;
          cnt_nxt     = PRE_LD;
        end else if (i_rd_req) begin
          rd_gnt_nxt  = 1'b1;
          last_wr_nxt = 1'b0;
          state_nxt   = RD_DATA;
          cnt_nxt     = BST_LD;
        end
      end
      WR_PRE: begin
        if (cnt_done) begin
          state_nxt = WR_DATA;
          cnt_nxt   = BST_LD;
        end
      end
      WR_DATA: begin
        if (cnt_done) begin
          // Chain another write with no postamble/preamble only if no read waits.
          if (i_wr_req && !i_rd_req) begin
            wr_gnt_nxt  = 1'b1;
            last_wr_nxt = 1'b1;
            cnt_nxt     = BST_LD;
          end else begin
            state_nxt = WR_POST;
            cnt_nxt   = POST_LD;
          end
        end
      end
      WR_POST: begin
        if (cnt_done) begin
          state_nxt = TURN;
          cnt_nxt   = TURN_LD;
        end
      end
      RD_DATA: begin
        if (cnt_done) begin
          state_nxt = TURN;
          cnt_nxt   = TURN_LD;
        end
      end
      TURN: begin
        if (cnt_done) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Registered pad controls and status, decoded from the state being entered.
  always_ff @(posedge i_controller_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wr_gnt        <= 1'b0;
      o_rd_gnt        <= 1'b0;
      o_dq_t          <= '1;
      o_dqs_t         <= '1;
      o_wr_data_en    <= 1'b0;
      o_rd_capture_en <= 1'b0;
      o_busy          <= 1'b0;
      o_state         <= 3'd0;
    end else begin
      o_wr_gnt        <= wr_gnt_nxt;
      o_rd_gnt        <= rd_gnt_nxt;
      o_dq_t          <= {LANES{state_nxt != WR_DATA}};
      o_dqs_t         <= {LANES{!(state_nxt inside {WR_PRE, WR_DATA, WR_POST})}};
      o_wr_data_en    <= (state_nxt == WR_DATA);
      o_rd_capture_en <= (state_nxt == RD_DATA);
      o_busy          <= (state_nxt != IDLE);
      o_state         <= state_nxt;
    end
  end

endmodule

// File: tb/tb_ddr3_dq_dir_ctrl.sv
// Bench for ddr3_dq_dir_ctrl: an interval-scheduling model of the bus plus
// directed scenarios with hand-computed edge-relative expectations.
module tb_ddr3_dq_dir_ctrl;
  localparam int L = 8, B = 4, P = 1, Q = 1, T = 2;
  localparam int N = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   wr_left = 0, rd_left = 0;
  logic wr_req, rd_req;
  assign wr_req = (wr_left > 0);
  assign rd_req = (rd_left > 0);

  logic         wr_gnt, rd_gnt, wr_en, rd_en, busy;
  logic [L-1:0] dq_t, dqs_t;
  logic [2:0]   state;

  ddr3_dq_dir_ctrl #(
    .LANES(L), .BURST_BEATS(B), .PREAMBLE_CYCLES(P),
    .POSTAMBLE_CYCLES(Q), .TURNAROUND_CYCLES(T)
  ) dut (
    .i_controller_clk(clk), .i_rst_n(rst_n),
    .i_wr_req(wr_req), .i_rd_req(rd_req),
    .o_wr_gnt(wr_gnt), .o_rd_gnt(rd_gnt),
    .o_dq_t(dq_t), .o_dqs_t(dqs_t),
    .o_wr_data_en(wr_en), .o_rd_capture_en(rd_en),
    .o_busy(busy), .o_state(state)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(string nm, int e, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s edge %0d got %0h expected %0h", nm, e, act, exp);
    end
  endtask

  // Model: per-edge expected state (0 idle,1 pre,2 wdata,3 post,4 rdata,5 turn)
  // and grant pulses, filled in whole bursts when a grant is decided.
  int edge_n = 0, free_at = 0, dec_at = -1;
  bit last_w = 1'b0;
  int st_c[N];
  bit wg_c[N], rg_c[N];

  task automatic fill(int a, int n, int v);
    for (int i = a; i < a + n; i++) if (i < N) st_c[i] = v;
  endtask

  always @(posedge clk or negedge rst_n) begin
    int e;
    if (!rst_n) begin
      free_at = edge_n; dec_at = -1; last_w = 1'b0;
      for (int i = edge_n; i < N; i++) begin st_c[i] = 0; wg_c[i] = 0; rg_c[i] = 0; end
    end else begin
      e = edge_n;
      if (dec_at == e) begin
        if (wr_req && !rd_req) begin
          wg_c[e] = 1; last_w = 1; fill(e, B, 2); dec_at = e + B;
        end else begin
          fill(e, Q, 3); fill(e + Q, T, 5); free_at = e + Q + T + 1; dec_at = -1;
        end
      end else if (dec_at < 0 && e >= free_at) begin
        if (wr_req && (!rd_req || !last_w)) begin
          wg_c[e] = 1; last_w = 1; fill(e, P, 1); fill(e + P, B, 2); dec_at = e + P + B;
        end else if (rd_req) begin
          rg_c[e] = 1; last_w = 0; fill(e, B, 4); fill(e + B, T, 5); free_at = e + B + T + 1;
        end
      end
      edge_n = e + 1;
    end
  end

  // Recorded DUT outputs per edge for the literal checks.
  logic [L-1:0] h_dq[N], h_dqs[N];
  bit h_wg[N], h_rg[N], h_wen[N], h_ren[N];
  int h_st[N];

  // Requesters drop after seeing a grant; compare DUT with model every cycle.
  always @(negedge clk) begin
    int e, s;
    logic [L-1:0] xdq, xdqs;
    if (wr_gnt && wr_left > 0) wr_left--;
    if (rd_gnt && rd_left > 0) rd_left--;
    if (chk_en && rst_n) begin
      e = edge_n - 1;
      s = st_c[e];
      xdqs = (s >= 1 && s <= 3) ? '0 : '1;
      xdq  = (s == 2) ? '0 : '1;
      chk("state",   e, int'(state),  s);
      chk("wr_gnt",  e, int'(wr_gnt), int'(wg_c[e]));
      chk("rd_gnt",  e, int'(rd_gnt), int'(rg_c[e]));
      chk("dq_t",    e, int'(dq_t),   int'(xdq));
      chk("dqs_t",   e, int'(dqs_t),  int'(xdqs));
      chk("wr_en",   e, int'(wr_en),  int'(s == 2));
      chk("rd_en",   e, int'(rd_en),  int'(s == 4));
      chk("busy",    e, int'(busy),   int'(s != 0));
      if (rd_en) chk("rd_no_drive", e, int'((&dq_t) && (&dqs_t)), 1);
      h_dq[e] = dq_t; h_dqs[e] = dqs_t; h_wg[e] = wr_gnt; h_rg[e] = rd_gnt;
      h_wen[e] = wr_en; h_ren[e] = rd_en; h_st[e] = int'(state);
    end
  end

  task automatic go(int w, int r, output int g);
    @(negedge clk);
    g = edge_n;
    wr_left = w;
    rd_left = r;
  endtask

  task automatic wait_quiet(int maxc);
    int n = 0;
    while (!(wr_left == 0 && rd_left == 0 && dec_at < 0 && edge_n > free_at) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxc) begin
      checks++; errors++;
      $display("FAIL timeout got %0d cycles expected fewer than %0d", n, maxc);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int g, cnt;
    // Reset values
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dq_t",  0, int'(dq_t), 8'hFF);
    chk("rst_dqs_t", 0, int'(dqs_t), 8'hFF);
    chk("rst_wr_en", 0, int'(wr_en), 0);
    chk("rst_rd_en", 0, int'(rd_en), 0);
    chk("rst_busy",  0, int'(busy), 0);
    chk("rst_gnt",   0, int'(wr_gnt | rd_gnt), 0);
    chk("rst_state", 0, int'(state), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) chk_en = 1'b1;
    repeat (3) @(negedge clk);

    // Single write: pre g, data g+1..g+4, post g+5, turn g+6..g+7, idle g+8
    go(1, 0, g); wait_quiet(60);
    chk("w1_gnt",      g,     int'(h_wg[g]), 1);
    chk("w1_dqs_lo0",  g,     int'(h_dqs[g]), 0);
    chk("w1_dqs_lo5",  g + 5, int'(h_dqs[g + 5]), 0);
    chk("w1_dqs_hi",   g + 6, int'(h_dqs[g + 6]), 8'hFF);
    chk("w1_wen_pre",  g,     int'(h_wen[g]), 0);
    chk("w1_wen_1",    g + 1, int'(h_wen[g + 1]), 1);
    chk("w1_wen_4",    g + 4, int'(h_wen[g + 4]), 1);
    chk("w1_wen_post", g + 5, int'(h_wen[g + 5]), 0);
    chk("w1_dq_data",  g + 2, int'(h_dq[g + 2]), 0);
    chk("w1_turn",     g + 7, h_st[g + 7], 5);
    chk("w1_idle",     g + 8, h_st[g + 8], 0);
    chk("mdl_w1_data", g + 1, st_c[g + 1], 2);

    // Single read: data g..g+3, turn g+4..g+5, idle g+6
    go(0, 1, g); wait_quiet(60);
    chk("r1_gnt",  g,     int'(h_rg[g]), 1);
    chk("r1_ren0", g,     int'(h_ren[g]), 1);
    chk("r1_ren3", g + 3, int'(h_ren[g + 3]), 1);
    chk("r1_ren4", g + 4, int'(h_ren[g + 4]), 0);
    chk("r1_turn", g + 5, h_st[g + 5], 5);
    chk("r1_idle", g + 6, h_st[g + 6], 0);
    cnt = 0;
    for (int i = g; i <= g + 6; i++) if (h_dq[i] == 8'hFF) cnt++;
    chk("r1_dq_hiz", g, cnt, 7);
    chk("mdl_r1_idle", g + 6, st_c[g + 6], 0);

    // Tie: write, read after turnaround, then write again
    go(2, 1, g); wait_quiet(100);
    chk("tie_w_first", g,      int'(h_wg[g]), 1);
    chk("tie_no_rd",   g,      int'(h_rg[g]), 0);
    chk("tie_rd",      g + 9,  int'(h_rg[g + 9]), 1);
    chk("tie_w_again", g + 16, int'(h_wg[g + 16]), 1);
    chk("mdl_tie_rd",  g + 9,  int'(rg_c[g + 9]), 1);

    // Seamless writes: 8 contiguous data beats, second grant at g+5
    go(2, 0, g); wait_quiet(100);
    cnt = 0;
    for (int i = g + 1; i <= g + 8; i++) if (h_wen[i]) cnt++;
    chk("sw_beats", g, cnt, 8);
    chk("sw_gnt2",  g + 5, int'(h_wg[g + 5]), 1);
    cnt = 0;
    for (int i = g; i <= g + 9; i++) if (h_dqs[i] == 8'h00) cnt++;
    chk("sw_dqs_held", g, cnt, 10);
    chk("sw_dqs_rel",  g + 10, int'(h_dqs[g + 10]), 8'hFF);
    chk("sw_idle",     g + 12, h_st[g + 12], 0);

    // Read then write (last grant was a write, so read wins the tie)
    go(1, 1, g); wait_quiet(100);
    chk("rw_rd",      g,     int'(h_rg[g]), 1);
    chk("rw_last_rd", g + 3, int'(h_ren[g + 3]), 1);
    chk("rw_wgnt",    g + 7, int'(h_wg[g + 7]), 1);
    chk("rw_gap",     g + 7, int'(h_wen[g + 7]), 0);
    chk("rw_first_w", g + 8, int'(h_wen[g + 8]), 1);

    // Staggered requests checked against the model only
    go(1, 0, g); repeat (2) @(negedge clk); rd_left = 1; wait_quiet(100);
    go(0, 1, g); @(negedge clk); wr_left = 2; wait_quiet(100);
    go(0, 1, g); repeat (3) @(negedge clk); wr_left = 1; wait_quiet(100);

    // Asynchronous reset in the middle of write data
    go(1, 0, g);
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_wen", g + 2, int'(wr_en), 1);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_dq_t",  0, int'(dq_t), 8'hFF);
    chk("arst_dqs_t", 0, int'(dqs_t), 8'hFF);
    chk("arst_wr_en", 0, int'(wr_en), 0);
    chk("arst_busy",  0, int'(busy), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    chk("arst_state", 0, int'(state), 0);
    @(posedge clk) chk_en = 1'b1;
    go(1, 1, g); wait_quiet(100);
    chk("arst_tie_w", g,      int'(h_wg[g]), 1);
    chk("arst_tie_r", g + 9,  int'(h_rg[g + 9]), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
